miniled_scan_ctrl: RTL

MINILED_SCAN_CTRL -- requirements
Module: miniled_scan_ctrl

---
 rtl/miniled_scan_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/miniled_scan_ctrl.sv
// Mini-LED scan controller: fetches grey words, shifts them to cascaded drivers, latches, then drives one row's GCLK burst. Build option: MINILED_AMBIENT_SCALE_EN.
// Latency: 1 cycle from accepted light_refresh to FETCH; 2 FETCH cycles per word (3 with ambient scaling), DCLK_DIV cycles per bit.
// Backpressure: none; refreshes during a frame merge into one pending request served after the frame completes.
module miniled_scan_ctrl #(
    parameter int SCANS       = 4,
    parameter int CHANNELS    = 16,
    parameter int GRAY_W      = 16,
    parameter int DCLK_DIV    = 4,
    parameter int GCLK_PULSES = 256
) (
    input  logic                                  I_clk,
    input  logic                                  I_rst_n,
    input  logic                                  light_refresh,
    output logic [$clog2(SCANS*CHANNELS)-1:0]     light_index,
    input  logic [GRAY_W-1:0]                     light,
    input  logic [7:0]                            amb_gain,
    output logic                                  LE,
    output logic                                  DCLK,
    output logic                                  SDI,
    output logic                                  GCLK,
    output logic [SCANS-1:0]                      scan,
    output logic                                  frame_busy
);
    localparam int IDX_W  = $clog2(SCANS*CHANNELS);
    localparam int ROW_W  = (SCANS > 1) ? $clog2(SCANS) : 1;
    localparam int WORD_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W  = $clog2(GRAY_W);
    localparam int PH_W   = $clog2(DCLK_DIV);
    localparam int CNT_W  = $clog2(2*GCLK_PULSES + DCLK_DIV + 4);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY, DEAD} state_t;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [WORD_W-1:0]   word;
    logic [BIT_W-1:0]    bitc;
    logic [PH_W-1:0]     ph;
    logic [CNT_W-1:0]    cnt;
    logic                pending;
    logic [GRAY_W-1:0]   sreg;
    logic [GRAY_W-1:0]   word_in;
    logic                accept;
    logic [1:0]          rst_sync;
    logic                rst_n;

    // Reset asserts asynchronously but releases two clock edges later.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n  = rst_sync[1];
    assign accept = (state == IDLE) && (light_refresh || pending);

`ifdef MINILED_AMBIENT_SCALE_EN
    localparam int FETCH_LAST = 2;
    logic [7:0]        gain_q;
    logic [GRAY_W-1:0] scaled_q;

    // light*(gain+1) never exceeds GRAY_W+8 bits, so >>8 then truncation loses nothing above.
    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_q   <= '0;
            scaled_q <= '0;
        end else begin
            if (accept) gain_q <= amb_gain;
            if (state == FETCH && cnt == CNT_W'(1))
                scaled_q <= GRAY_W'((64'(light) * (64'(gain_q) + 64'd1)) >> 8);
        end
    end
    assign word_in = scaled_q;
`else
    localparam int FETCH_LAST = 1;
    logic unused_amb;
    assign unused_amb = ^amb_gain;
    assign word_in    = light;
`endif

    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            word        <= '0;
            bitc        <= '0;
            ph          <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            sreg        <= '0;
            light_index <= '0;
            LE          <= 1'b0;
            DCLK        <= 1'b0;
            SDI         <= 1'b0;
            GCLK        <= 1'b0;
            scan        <= '0;
            frame_busy  <= 1'b0;
        end else begin
            if (light_refresh && frame_busy) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pending     <= 1'b0;
                        frame_busy  <= 1'b1;
                        row         <= '0;
                        word        <= '0;
                        cnt         <= '0;
                        light_index <= '0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (cnt == CNT_W'(FETCH_LAST)) begin
                        cnt   <= '0;
                        ph    <= '0;
                        bitc  <= '0;
                        sreg  <= word_in;
                        SDI   <= word_in[GRAY_W-1];
                        DCLK  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (ph == PH_W'(DCLK_DIV-1)) begin
                        ph   <= '0;
                        DCLK <= 1'b0;
                        if (bitc == BIT_W'(GRAY_W-1)) begin
                            bitc <= '0;
                            cnt  <= '0;
                            if (word == WORD_W'(CHANNELS-1)) begin
                                LE    <= 1'b1;
                                state <= LATCH;
                            end else begin
                                word        <= word + WORD_W'(1);
                                light_index <= light_index + IDX_W'(1);
                                state       <= FETCH;
                            end
                        end else begin
                            // Next bit appears on the same edge DCLK falls.
                            bitc <= bitc + BIT_W'(1);
                            sreg <= sreg << 1;
                            SDI  <= sreg[GRAY_W-2];
                        end
                    end else begin
                        ph   <= ph + PH_W'(1);
                        DCLK <= (ph + PH_W'(1) >= PH_W'(DCLK_DIV/2));
                    end
                end
                LATCH: begin
                    if (cnt == CNT_W'(DCLK_DIV-1)) begin
                        LE    <= 1'b0;
                        cnt   <= '0;
                        GCLK  <= 1'b0;
                        scan  <= SCANS'(1) << row;
                        state <= DISPLAY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DISPLAY: begin
                    if (cnt == CNT_W'(2*GCLK_PULSES-1)) begin
                        GCLK  <= 1'b0;
                        scan  <= '0;
                        cnt   <= '0;
                        state <= DEAD;
                    end else begin
                        GCLK <= ~GCLK;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DEAD: begin
                    if (cnt == CNT_W'(DCLK_DIV-1)) begin
                        cnt <= '0;
                        if (row == ROW_W'(SCANS-1)) begin
                            row         <= '0;
                            light_index <= '0;
                            frame_busy  <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            // Buffer is row-major, so the next row starts at the next index.
                            row         <= row + ROW_W'(1);
                            word        <= '0;
                            light_index <= light_index + IDX_W'(1);
                            state       <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
